led_step_sequencer: RTL and testbench

//  Parametrised step sequencer for board LED/status displays; generalises the go/count/done FSM.

---
 rtl/led_step_sequencer_pkg.sv | 23 ++
 rtl/led_step_sequencer_if.sv | 28 ++
 rtl/led_step_sequencer_tick.sv | 29 ++
 rtl/led_step_sequencer.sv | 136 +++++++++++++
 tb/tb_led_step_sequencer.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/led_step_sequencer_pkg.sv
// led_step_sequencer_pkg
//   Shared definitions for the LED step sequencer. The top-level LED decode
//   uses the SEQ_* state codes, which this package exports.
//   Contents: state code constants, the FSM state enum, and the tick divisor helper.
package led_step_sequencer_pkg;

    localparam logic [1:0] SEQ_IDLE = 2'b00;
    localparam logic [1:0] SEQ_RUN  = 2'b01;
    localparam logic [1:0] SEQ_DONE = 2'b10;

    // Code 2'b11 is unused and is steered back to IDLE by the FSM.
    typedef enum logic [1:0] {
        ST_IDLE = SEQ_IDLE,
        ST_RUN  = SEQ_RUN,
        ST_DONE = SEQ_DONE
    } seq_state_e;

    // Clock cycles per count step.
    function automatic int calc_tick_div(input int clk_freq, input int step_hz);
        return clk_freq / step_hz;
    endfunction

endpackage

// File: rtl/led_step_sequencer_if.sv
// led_step_sequencer_if
//   Control and status bundle between the button logic and the sequencer.
//   master: drives go/pause/abort/dir_down/loop_en/limit and observes the status.
//   slave : the sequencer, which drives count/busy/done/wrap.
interface led_step_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             go;
    logic             pause;
    logic             abort;
    logic             dir_down;
    logic             loop_en;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             wrap;

    modport master (
        output go, pause, abort, dir_down, loop_en, limit,
        input  count, busy, done, wrap
    );

    modport slave (
        input  go, pause, abort, dir_down, loop_en, limit,
        output count, busy, done, wrap
    );
endinterface

// File: rtl/led_step_sequencer_tick.sv
// tick_divider
//   Produces a one-cycle tick enable every DIV enabled cycles. No derived clock is created.
//   Ports: i_clk, i_rst (synchronous, active high), i_en (count enable; the value
//          holds while this is low), i_clr (forces the count to 0 and wins over
//          i_en), o_tick (high on the enabled cycle where the count is DIV-1).
module tick_divider #(
    parameter int DIV = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end

    assign o_tick = i_en && !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/led_step_sequencer.sv
// led_step_sequencer
//   Steps a WIDTH-bit counter from a start value to a terminal value at STEP_HZ.
//   The count runs up or down, and the sequencer either stops or loops at the
//   terminal value. Everything runs in the clk30 domain on a tick enable.
//   Ports: i_clk30, i_rst (synchronous, active high), bus (slave modport):
//          go (a rising edge starts a run), pause, abort, dir_down, loop_en,
//          limit (these three are latched at start), and the registered status
//          outputs count, busy, done, wrap.
module led_step_sequencer
    import led_step_sequencer_pkg::*;
#(
    parameter int CLK_FREQ = 30000000,
    parameter int STEP_HZ  = 4,
    parameter int WIDTH    = 4
) (
    input  logic                 i_clk30,
    input  logic                 i_rst,
    led_step_sequencer_if.slave  bus
);
    localparam int TICK_DIV = calc_tick_div(CLK_FREQ, STEP_HZ);

    seq_state_e       r_state, w_next_state;
    logic             r_go_d;
    logic             r_dir_down, r_loop_en;
    logic [WIDTH-1:0] r_limit;
    logic [WIDTH-1:0] r_count, w_next_count;
    logic             r_busy, r_done, r_wrap, w_next_wrap;
    logic             w_start, w_tick;
    logic [WIDTH-1:0] w_first, w_end, w_new_first;

    // The go history updates every cycle, even while abort is high. This way a
    // go held across an abort does not produce a fresh start afterwards.
    always_ff @(posedge i_clk30) begin
        if (i_rst) r_go_d <= 1'b0;
        else       r_go_d <= bus.go;
    end

    assign w_start = bus.go && !r_go_d;

    // Start or abort re-phases the divider, so the first step lands exactly
    // TICK_DIV cycles after the start.
    tick_divider #(.DIV(TICK_DIV)) u_tick (
        .i_clk  (i_clk30),
        .i_rst  (i_rst),
        .i_en   ((r_state == ST_RUN) && !bus.pause),
        .i_clr  (w_start || bus.abort),
        .o_tick (w_tick)
    );

    // Run endpoints come from the latched mode. A new start uses the live inputs.
    assign w_first     = r_dir_down ? r_limit : '0;
    assign w_end       = r_dir_down ? '0 : r_limit;
    assign w_new_first = bus.dir_down ? bus.limit : '0;

    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        w_next_wrap  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next_count = '0;
                if (w_start) begin
                    w_next_state = ST_RUN;
                    w_next_count = w_new_first;
                end
            end
            ST_RUN: begin
                if (w_start) begin
                    w_next_count = w_new_first;
                end else if (w_tick) begin
                    if (r_count == w_end) begin
                        if (r_loop_en) begin
                            w_next_count = w_first;
                            w_next_wrap  = 1'b1;
                        end else begin
                            w_next_state = ST_DONE;
                        end
                    end else begin
                        w_next_count = r_dir_down ? r_count - WIDTH'(1) : r_count + WIDTH'(1);
                    end
                end
            end
            ST_DONE: begin
                if (w_start) begin
                    w_next_state = ST_RUN;
                    w_next_count = w_new_first;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_count = '0;
            end
        endcase
        // Abort overrides any simultaneous start or tick.
        if (bus.abort) begin
            w_next_state = ST_IDLE;
            w_next_count = '0;
            w_next_wrap  = 1'b0;
        end
    end

    always_ff @(posedge i_clk30) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
            r_busy  <= (w_next_state == ST_RUN);
            r_done  <= (w_next_state == ST_DONE);
            r_wrap  <= w_next_wrap;
        end
    end

    // The mode is captured only on an accepted start. Later changes wait for the next start.
    always_ff @(posedge i_clk30) begin
        if (i_rst) begin
            r_dir_down <= 1'b0;
            r_loop_en  <= 1'b0;
            r_limit    <= '0;
        end else if (w_start && !bus.abort) begin
            r_dir_down <= bus.dir_down;
            r_loop_en  <= bus.loop_en;
            r_limit    <= bus.limit;
        end
    end

    assign bus.count = r_count;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.wrap  = r_wrap;

endmodule

// File: tb/tb_led_step_sequencer.sv
// Testbench for led_step_sequencer with CLK_FREQ=8, STEP_HZ=1 (TICK_DIV=8), WIDTH=4.
module tb_led_step_sequencer;

    typedef struct {
        logic       rst, go, pause, abort, dir_down, loop_en;
        logic [3:0] limit;
        int         ncyc;
        int         e_count, e_busy, e_done, e_wrap;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    led_step_sequencer_if #(.WIDTH(4)) bus();

    led_step_sequencer #(.CLK_FREQ(8), .STEP_HZ(1), .WIDTH(4)) dut (
        .i_clk30 (clk),
        .i_rst   (rst),
        .bus     (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic g, input logic p, input logic a,
                       input logic dn, input logic lp, input int lim, input int n,
                       input int ec, input int eb, input int ed, input int ew);
        vec_t v;
        v.rst = r; v.go = g; v.pause = p; v.abort = a; v.dir_down = dn; v.loop_en = lp;
        v.limit = 4'(lim); v.ncyc = n;
        v.e_count = ec; v.e_busy = eb; v.e_done = ed; v.e_wrap = ew;
        vecs.push_back(v);
    endtask

    initial begin
        int wraps, consec, nonzero, n, lat;
        logic prev;

        rst = 1'b1;
        bus.go = 0; bus.pause = 0; bus.abort = 0; bus.dir_down = 0; bus.loop_en = 0; bus.limit = 0;

        //   rst go pa ab dn lp lim n    cnt busy done wrap
        // reset
        add(1, 0, 0, 0, 0, 0, 0, 2,    0, 0, 0, 0);
        // up one-shot, limit 3
        add(0, 1, 0, 0, 0, 0, 3, 1,    0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 3, 7,    0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 3, 1,    1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 3, 7,    1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 3, 1,    2, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 3, 7,    2, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 3, 1,    3, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 3, 7,    3, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 3, 1,    3, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 3, 10,   3, 0, 1, 0);
        // down looping, limit 2, started from DONE; mode inputs changed mid-run
        add(0, 1, 0, 0, 1, 1, 2, 1,    2, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 9, 7,    2, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 9, 1,    1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 9, 7,    1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 9, 1,    0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 9, 7,    0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 9, 1,    2, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 9, 1,    2, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 9, 6,    2, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 9, 1,    1, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 9, 1,    0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 9, 3,    0, 0, 0, 0);
        // abort together with a go rising edge during RUN; go held high afterwards
        add(0, 1, 0, 0, 0, 0, 5, 1,    0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 5, 8,    1, 1, 0, 0);
        add(0, 1, 0, 1, 0, 0, 5, 1,    0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 5, 10,   0, 0, 0, 0);
        // pause held for 20 cycles with the divider at 3
        add(0, 0, 0, 0, 0, 0, 5, 1,    0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 5, 1,    0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 5, 3,    0, 1, 0, 0);
        add(0, 0, 1, 0, 0, 0, 5, 20,   0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 5, 4,    0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 5, 1,    1, 1, 0, 0);
        // limit lowered to 2 mid-run has no effect; reset at count 5
        add(0, 0, 0, 0, 0, 0, 2, 7,    1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 2, 1,    2, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 2, 7,    2, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 2, 1,    3, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 2, 7,    3, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 2, 1,    4, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 2, 7,    4, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 2, 1,    5, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 2, 1,    0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 2, 8,    0, 0, 0, 0);
        // limit 0 one-shot, then restart from DONE
        add(0, 1, 0, 0, 0, 0, 0, 1,    0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 7,    0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1,    0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0, 1,    0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 7,    0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1,    0, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst          = vecs[i].rst;
            bus.go       = vecs[i].go;
            bus.pause    = vecs[i].pause;
            bus.abort    = vecs[i].abort;
            bus.dir_down = vecs[i].dir_down;
            bus.loop_en  = vecs[i].loop_en;
            bus.limit    = vecs[i].limit;
            repeat (vecs[i].ncyc) step();
            chk($sformatf("v%0d count", i), int'(bus.count), vecs[i].e_count);
            chk($sformatf("v%0d busy", i),  int'(bus.busy),  vecs[i].e_busy);
            chk($sformatf("v%0d done", i),  int'(bus.done),  vecs[i].e_done);
            chk($sformatf("v%0d wrap", i),  int'(bus.wrap),  vecs[i].e_wrap);
        end

        // Looping with limit 0: wrap pulses once per tick, each pulse one cycle wide.
        bus.go = 1; bus.dir_down = 0; bus.loop_en = 1; bus.limit = 0;
        step();
        chk("loop0 busy", int'(bus.busy), 1);
        bus.go = 0;
        wraps = 0; consec = 0; nonzero = 0; prev = 1'b0;
        for (int k = 0; k < 24; k++) begin
            step();
            if (bus.wrap) wraps++;
            if (bus.wrap && prev) consec++;
            if (bus.count != 0) nonzero++;
            prev = bus.wrap;
        end
        chk("loop0 wraps", wraps, 3);
        chk("loop0 wide_wrap", consec, 0);
        chk("loop0 nonzero", nonzero, 0);

        // Abort takes effect on the next cycle.
        bus.abort = 1;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.busy && n < 4);
        chk("abort busy", int'(bus.busy), 0);
        chk("abort latency", n, 1);
        bus.abort = 0;
        step();

        // Down one-shot with limit 1: done arrives two step periods after the start.
        bus.go = 1; bus.dir_down = 1; bus.loop_en = 0; bus.limit = 1;
        step();
        chk("down1 start count", int'(bus.count), 1);
        bus.go = 0;
        lat = 0;
        while (!bus.done && lat < 40) begin
            step();
            lat++;
        end
        chk("down1 done latency", lat, 16);
        chk("down1 end count", int'(bus.count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
